// File: rtl/lock_seq_ctrl.sv
// Combination-lock sequencer: collects keypad digits, compares them against the
// stored code, counts failed attempts and enforces a timed lockout.
module lock_seq_ctrl #(
    parameter int                      NUM_DIGITS     = 6,
    parameter int                      MAX_FAILS      = 3,
    parameter int                      LOCKOUT_CYCLES = 16,
    parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE   = 24'h123456
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [3:0]                           digit_in,
    input  logic                                 digit_valid,
    input  logic                                 relock,
    input  logic                                 cfg_we,
    input  logic [4*NUM_DIGITS-1:0]              cfg_code,
    output logic [1:0]                           msg_sel,
    output logic [$clog2(NUM_DIGITS+1)-1:0]      entry_cnt,
    output logic [3:0]                           last_digit,
    output logic                                 digit_err,
    output logic [$clog2(MAX_FAILS+1)-1:0]       fail_cnt,
    output logic                                 cfg_ack
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int EW = $clog2(NUM_DIGITS + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPEN    = 2'd1,
        ERROR   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [EW-1:0]   entry_n;
    logic [3:0]      last_n;
    logic            err_n;
    logic [FW-1:0]   fail_n;
    logic            ack_n;
    logic            match, match_n;
    logic [TW-1:0]   timer, timer_n;
    logic [CW-1:0]   code, code_n;
    logic [3:0]      code_nib;
    logic            match_acc;
    logic [FW-1:0]   fail_inc;

    function automatic logic all_bcd(input logic [CW-1:0] c);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    assign msg_sel = state;

    // The first digit of an attempt is compared against the most significant nibble.
    always_comb begin
        code_nib = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (entry_cnt == EW'(NUM_DIGITS - 1 - i)) code_nib = code[4*i +: 4];
        end
    end

    assign match_acc = match & (digit_in == code_nib);
    assign fail_inc  = (fail_cnt < FW'(MAX_FAILS)) ? fail_cnt + FW'(1) : fail_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= CLOSED;
            entry_cnt  <= '0;
            last_digit <= 4'h0;
            digit_err  <= 1'b0;
            fail_cnt   <= '0;
            cfg_ack    <= 1'b0;
            match      <= 1'b1;
            timer      <= '0;
            code       <= DEFAULT_CODE;
        end else begin
            state      <= state_n;
            entry_cnt  <= entry_n;
            last_digit <= last_n;
            digit_err  <= err_n;
            fail_cnt   <= fail_n;
            cfg_ack    <= ack_n;
            match      <= match_n;
            timer      <= timer_n;
            code       <= code_n;
        end
    end

    always_comb begin
        state_n = state;
        entry_n = entry_cnt;
        last_n  = last_digit;
        err_n   = 1'b0;
        fail_n  = fail_cnt;
        ack_n   = 1'b0;
        match_n = match;
        timer_n = timer;
        code_n  = code;
        case (state)
            CLOSED: begin
                if (relock) begin
                    entry_n = '0;
                    match_n = 1'b1;
                end else if (digit_valid) begin
                    if (digit_in > 4'd9) begin
                        err_n = 1'b1;
                    end else begin
                        last_n = digit_in;
                        if (entry_cnt == EW'(NUM_DIGITS - 1)) begin
                            // Attempt complete: verdict only now, never early.
                            entry_n = '0;
                            match_n = 1'b1;
                            if (match_acc) begin
                                state_n = OPEN;
                                fail_n  = '0;
                            end else begin
                                fail_n = fail_inc;
                                if (fail_inc == FW'(MAX_FAILS)) begin
                                    state_n = LOCKOUT;
                                    timer_n = TW'(LOCKOUT_CYCLES - 1);
                                end else begin
                                    state_n = ERROR;
                                end
                            end
                        end else begin
                            entry_n = entry_cnt + EW'(1);
                            match_n = match_acc;
                        end
                    end
                end
            end
            OPEN: begin
                if (relock) begin
                    state_n = CLOSED;
                    match_n = 1'b1;
                end else if (cfg_we && all_bcd(cfg_code)) begin
                    code_n = cfg_code;
                    ack_n  = 1'b1;
                end
            end
            ERROR: begin
                if (relock) state_n = CLOSED;
            end
            LOCKOUT: begin
                if (timer == '0) begin
                    state_n = CLOSED;
                    fail_n  = '0;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: state_n = CLOSED;
        endcase
    end

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl: a digit-queue reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_lock_seq_ctrl;

    localparam int ND = 6;
    localparam int MF = 3;
    localparam int LC = 16;
    localparam logic [23:0] DEF = 24'h123456;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        relock;
    logic        cfg_we;
    logic [23:0] cfg_code;
    logic [1:0]  msg_sel;
    logic [2:0]  entry_cnt;
    logic [3:0]  last_digit;
    logic        digit_err;
    logic [1:0]  fail_cnt;
    logic        cfg_ack;

    int checks = 0;
    int errors = 0;

    lock_seq_ctrl #(
        .NUM_DIGITS(ND), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC), .DEFAULT_CODE(DEF)
    ) dut (
        .clock(clock), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
        .relock(relock), .cfg_we(cfg_we), .cfg_code(cfg_code), .msg_sel(msg_sel),
        .entry_cnt(entry_cnt), .last_digit(last_digit), .digit_err(digit_err),
        .fail_cnt(fail_cnt), .cfg_ack(cfg_ack)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: digits entered so far are kept in a queue and compared
    // against the code as a whole once the attempt is complete.
    int          m_state;
    int          m_entered[$];
    int          m_last, m_err, m_fail, m_ack, m_left;
    logic [23:0] m_code;

    initial begin
        m_state = 0; m_last = 0; m_err = 0; m_fail = 0; m_ack = 0; m_left = 0;
        m_code = DEF;
        forever begin
            @(posedge clock);
            if (!reset) begin
                m_state = 0; m_entered.delete(); m_last = 0; m_err = 0;
                m_fail = 0; m_ack = 0; m_left = 0; m_code = DEF;
            end else begin
                m_err = 0;
                m_ack = 0;
                case (m_state)
                    0: begin
                        if (relock) m_entered.delete();
                        else if (digit_valid) begin
                            if (int'(digit_in) > 9) m_err = 1;
                            else begin
                                bit ok;
                                m_last = int'(digit_in);
                                m_entered.push_back(int'(digit_in));
                                if (m_entered.size() == ND) begin
                                    ok = 1;
                                    for (int i = 0; i < ND; i++)
                                        if (m_entered[i] != int'(m_code[4*(ND-1-i) +: 4])) ok = 0;
                                    m_entered.delete();
                                    if (ok) begin
                                        m_state = 1; m_fail = 0;
                                    end else begin
                                        if (m_fail < MF) m_fail++;
                                        if (m_fail == MF) begin
                                            m_state = 3; m_left = LC;
                                        end else m_state = 2;
                                    end
                                end
                            end
                        end
                    end
                    1: begin
                        if (relock) m_state = 0;
                        else if (cfg_we) begin
                            bit good;
                            good = 1;
                            for (int i = 0; i < ND; i++)
                                if (int'(cfg_code[4*i +: 4]) > 9) good = 0;
                            if (good) begin
                                m_code = cfg_code; m_ack = 1;
                            end
                        end
                    end
                    2: if (relock) m_state = 0;
                    default: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_state = 0; m_fail = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            chk("msg_sel", int'(msg_sel), m_state);
            chk("entry_cnt", int'(entry_cnt), m_entered.size());
            chk("last_digit", int'(last_digit), m_last);
            chk("digit_err", int'(digit_err), m_err);
            chk("fail_cnt", int'(fail_cnt), m_fail);
            chk("cfg_ack", int'(cfg_ack), m_ack);
        end
    end

    // Each task starts at a falling edge and returns at the falling edge after
    // the strobe has been registered.
    task automatic digit(input logic [3:0] d);
        digit_in = d; digit_valid = 1'b1;
        @(negedge clock);
        digit_valid = 1'b0;
    endtask

    task automatic enter_code(input logic [23:0] c);
        for (int i = ND - 1; i >= 0; i--) digit(c[4*i +: 4]);
    endtask

    task automatic do_relock();
        relock = 1'b1;
        @(negedge clock);
        relock = 1'b0;
    endtask

    task automatic write_code(input logic [23:0] c);
        cfg_code = c; cfg_we = 1'b1;
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    int lock_cycles;

    initial begin
        reset = 1'b0; digit_in = 4'h0; digit_valid = 1'b0; relock = 1'b0;
        cfg_we = 1'b0; cfg_code = 24'h0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        chk("rst_msg", int'(msg_sel), 0);
        chk("rst_entry", int'(entry_cnt), 0);
        chk("rst_fail", int'(fail_cnt), 0);

        // Correct code opens the lock.
        for (int i = 1; i <= 5; i++) begin
            digit(4'(i));
            chk("t1_entry_step", int'(entry_cnt), i);
        end
        digit(4'd6);
        chk("t1_open", int'(msg_sel), 1);
        chk("t1_entry0", int'(entry_cnt), 0);
        chk("t1_last", int'(last_digit), 6);
        do_relock();

        // Wrong code, ignored digits in ERROR, fail count retained on relock.
        enter_code(24'h123457);
        chk("t2_error", int'(msg_sel), 2);
        chk("t2_fail", int'(fail_cnt), 1);
        digit(4'd3);
        chk("t2_ignored_entry", int'(entry_cnt), 0);
        chk("t2_ignored_last", int'(last_digit), 7);
        do_relock();
        chk("t2_closed", int'(msg_sel), 0);
        chk("t2_fail_kept", int'(fail_cnt), 1);

        // Three consecutive failures lock out for exactly LC cycles.
        enter_code(DEF);
        do_relock();
        for (int k = 0; k < 3; k++) begin
            enter_code(24'h999999);
            if (k < 2) do_relock();
        end
        chk("t3_lockout", int'(msg_sel), 3);
        chk("t3_fail_sat", int'(fail_cnt), 3);
        lock_cycles = 1;
        for (int c = 0; c < 40; c++) begin
            relock = c[0]; digit_valid = ~c[0]; digit_in = 4'd1;
            @(negedge clock);
            if (msg_sel != 2'd3) break;
            lock_cycles++;
        end
        relock = 1'b0; digit_valid = 1'b0;
        chk("t3_lock_len", lock_cycles, 16);
        chk("t3_closed", int'(msg_sel), 0);
        chk("t3_fail_clr", int'(fail_cnt), 0);

        // Non-BCD digit and relock with a simultaneous digit.
        digit(4'hC);
        chk("t4_err_pulse", int'(digit_err), 1);
        chk("t4_entry_hold", int'(entry_cnt), 0);
        digit(4'd5);
        chk("t4_err_gone", int'(digit_err), 0);
        chk("t4_entry1", int'(entry_cnt), 1);
        relock = 1'b1;
        digit(4'd1);
        relock = 1'b0;
        chk("t4_relock_entry", int'(entry_cnt), 0);
        chk("t4_relock_last", int'(last_digit), 5);

        // Reprogramming the code while open.
        enter_code(DEF);
        write_code(24'h908172);
        chk("t5_ack", int'(cfg_ack), 1);
        @(negedge clock);
        chk("t5_ack_pulse", int'(cfg_ack), 0);
        do_relock();
        enter_code(24'h908172);
        chk("t5_new_open", int'(msg_sel), 1);
        do_relock();
        enter_code(DEF);
        chk("t5_old_err", int'(msg_sel), 2);
        do_relock();
        enter_code(24'h908172);
        write_code(24'h12345A);
        chk("t5_bad_noack", int'(cfg_ack), 0);
        relock = 1'b1;
        write_code(24'h123456);
        relock = 1'b0;
        chk("t5_prio_noack", int'(cfg_ack), 0);
        chk("t5_prio_closed", int'(msg_sel), 0);
        enter_code(24'h908172);
        chk("t5_code_kept", int'(msg_sel), 1);
        do_relock();

        // Reset mid-entry restores the default code.
        digit(4'd1); digit(4'd2); digit(4'd3);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("t6_entry", int'(entry_cnt), 0);
        chk("t6_msg", int'(msg_sel), 0);
        enter_code(DEF);
        chk("t6_default_open", int'(msg_sel), 1);

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_seq_ctrl.md
Name: lock_seq_ctrl

Overview:
Sequencing controller for the combination-lock datapath. It accepts one keypad digit per strobe and compares the entry digit-by-digit against a stored code. It tracks failed attempts and enforces a timed lockout. It drives a message selector and the last-digit value to the six-digit HEX decoder, and allows the code to be reprogrammed only while the lock is open.

Parameters:
NUM_DIGITS, 6, digits per combination (1..7)
MAX_FAILS, 3, consecutive failed combinations that trigger lockout (>=1)
LOCKOUT_CYCLES, 16, clock cycles spent in LOCKOUT (>=1)
DEFAULT_CODE, 24'h123456, reset value of the code register; BCD, 4*NUM_DIGITS bits; the first digit entered is compared against the MS nibble

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
digit_in  in  4  keypad digit
digit_valid  in  1  one-cycle strobe; digit_in is sampled on this cycle
relock  in  1  request to close the lock or clear the current entry
cfg_we  in  1  code write strobe
cfg_code  in  4*NUM_DIGITS  new code, BCD
msg_sel  out  2  0=CLOSED, 1=OPEN, 2=ERROR, 3=LOCKOUT
entry_cnt  out  $clog2(NUM_DIGITS+1)  valid digits accepted in the current attempt
last_digit  out  4  most recent accepted digit
digit_err  out  1  one-cycle pulse: a non-BCD digit was presented
fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failed attempts
cfg_ack  out  1  one-cycle pulse: code register written

Behaviour:
- All outputs are registered. Every response appears in the cycle after the triggering strobe (1-cycle latency).
- Reset (reset==0 at a clock edge) has top priority in every state, including mid-entry and mid-lockout. It sets:
  - state=CLOSED, msg_sel=0, entry_cnt=0, last_digit=0, digit_err=0, fail_cnt=0, cfg_ack=0
  - match flag=1, lockout timer=0
  - code register=DEFAULT_CODE
- CLOSED state:
  - relock=1: clear entry_cnt and set match=1. A digit strobe in the same cycle is ignored.
  - digit_valid with digit_in>9: pulse digit_err for one cycle. The digit is not counted and entry_cnt and match are unchanged.
  - digit_valid with a BCD digit:
    - last_digit<=digit_in
    - match<=match & (digit_in == code nibble[entry_cnt])
    - entry_cnt++
  - When the accepted digit is number NUM_DIGITS:
    - match: next state is OPEN; entry_cnt<=0; fail_cnt<=0.
    - mismatch: fail_cnt++ and entry_cnt<=0. Next state is LOCKOUT if the new fail_cnt==MAX_FAILS, otherwise ERROR.
  - A mismatch is never reported early; all NUM_DIGITS digits are always collected.
- OPEN state (msg_sel=1):
  - Digit strobes are ignored.
  - cfg_we=1: code register<=cfg_code and cfg_ack pulses. Any nibble >9 in cfg_code rejects the whole write: no update and no cfg_ack.
  - relock=1: go to CLOSED with match=1. relock has priority over cfg_we in the same cycle, so that write is dropped.
- ERROR state (msg_sel=2):
  - Digit strobes and cfg_we are ignored.
  - relock: go to CLOSED. fail_cnt is retained.
- LOCKOUT state (msg_sel=3):
  - On entry the timer loads LOCKOUT_CYCLES-1 and decrements every cycle.
  - digit_valid, relock and cfg_we are all ignored.
  - When the timer reaches 0: next state is CLOSED and fail_cnt<=0. Total residency is exactly LOCKOUT_CYCLES cycles.
- cfg_we outside OPEN is ignored silently (no cfg_ack).
- fail_cnt saturates at MAX_FAILS and cannot wrap.
- entry_cnt never exceeds NUM_DIGITS-1 while visible in CLOSED.

Test Plan:
1. Reset low 2 cycles, then high; enter 1,2,3,4,5,6 with one strobe each -> entry_cnt steps 1..5, then 0 with msg_sel=1 the cycle after the 6th strobe; fail_cnt=0; last_digit=6.
2. Enter 1,2,3,4,5,7 -> msg_sel=2, fail_cnt=1; digit strobes in ERROR are ignored; relock -> msg_sel=0, fail_cnt stays 1.
3. Three wrong combinations in a row -> msg_sel=3 after the 3rd. It holds for exactly 16 cycles regardless of relock or digit strobes, then msg_sel=0 and fail_cnt=0.
4. In CLOSED, strobe digit_in=4'hC -> digit_err pulses 1 cycle and entry_cnt is unchanged. Strobe 1 together with relock=1 -> entry_cnt=0 and last_digit is unchanged.
5. Open the lock; cfg_we with 24'h908172 -> cfg_ack pulses. relock, enter 9,0,8,1,7,2 -> OPEN; entering 1..6 now -> ERROR. cfg_we with 24'h12345A while OPEN -> no cfg_ack and the code is unchanged.
6. Enter 1,2,3 then drive reset=0 for one cycle -> entry_cnt=0, msg_sel=0, code restored to 24'h123456 (verified by opening with 1..6).
